snitch_ssr_tcdm_cut: RTL and testbench
======================================

# snitch_ssr_tcdm_cut

Registered cut between an SSR data mover's TCDM master port (`mem_req_o`/`mem_rsp_i`) and the cluster TCDM interconnect. A two-entry spill register breaks the combinational `q_ready` path at full throughput. Responses pass through an optional one-cycle response register. An outstanding-request counter bounds in-flight transactions and reports when the port is idle, so the SSR can be safely reconfigured.

## Interface
- `AddrWidth`, 0: TCDM address width; must be >0.
- `DataWidth`, 0: TCDM data width; must be >0.
- `tcdm_req_t`, logic: request struct with `q_valid` and `q` (`addr`, `write`, `amo`, `data`, `strb`, `user`).
- `tcdm_rsp_t`, logic: response struct with `q_ready`, `p_valid`, `p.data`.
- `RspCut`, 1: 1 = register the response path; 0 = pass the response through combinationally.
- `MaxOutstanding`, 8: maximum number of accepted-but-unanswered downstream requests; range 1..255.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `slv_req_i`  in  tcdm_req_t  request from the SSR.
- `slv_rsp_o`  out  tcdm_rsp_t  response to the SSR.
- `mst_req_o`  out  tcdm_req_t  request to the interconnect.
- `mst_rsp_i`  in  tcdm_rsp_t  response from the interconnect.
- `idle_o`  out  1  high when there is no buffered request, no outstanding request and no pending registered response.
- `outstanding_o`  out  $clog2(MaxOutstanding+1)  current in-flight count.

## Operation
- **Spill register.** Two entries: A (output stage) and B (skid).
  - `slv_rsp_o.q_ready` = ~B.valid; it is a registered term only.
  - A slave handshake writes into A if A is empty or A drains in the same cycle; otherwise it writes into B.
  - When A drains and B is valid, B moves to A.
  - Ordering is strictly FIFO. The payload is never modified.
- **Request output.** `mst_req_o.q_valid` = A.valid & ~cnt_full, where cnt_full = (count == MaxOutstanding). `mst_req_o.q` = A payload.
- **Outstanding counter.**
  - +1 on `mst_req_o.q_valid & mst_rsp_i.q_ready`.
  - −1 on `mst_rsp_i.p_valid`.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding, because issue is gated.
  - A `p_valid` while the count is 0 is a protocol error: the count holds at 0 and a simulation assertion fires.
- **Response path.** Writes also return a `p_valid`.
  - RspCut=1: `p_valid` and `p.data` are registered. The data register loads only when `p_valid` is high; `p_valid` is registered every cycle.
  - RspCut=0: `slv_rsp_o.p` and `p_valid` equal `mst_rsp_i`.
  - There is no response back-pressure in either mode. The SSR's credit counter guarantees it can sink every response.
- **Idle.** `idle_o` = ~A.valid & ~B.valid & (count==0) & ~(RspCut & rsp_valid_q).
- **Reset** (`rst_i` high, asynchronous):
  - A.valid, B.valid, count and rsp_valid_q are cleared immediately.
  - Resulting outputs: `mst_req_o.q_valid`=0, `slv_rsp_o.q_ready`=1, `slv_rsp_o.p_valid`=0, `idle_o`=1, `outstanding_o`=0.
  - Data registers are not reset.
  - Reset mid-operation discards buffered requests and forgets outstanding ones. Responses arriving after reset deassertion are dropped, because the count is 0 (assertion suppressed for 4 cycles after reset).

## Timing
- Request latency: slave handshake in cycle t → `mst_req_o.q_valid` in t+1 (A was empty).
- Throughput: one request per cycle sustained while downstream `q_ready`=1 and cnt_full=0.
- Downstream stall: the first stalled request sits in A and the next lands in B. `slv q_ready` drops in the following cycle. No request is lost or duplicated.
- Response latency: RspCut=1 → interconnect `p_valid` in t appears at `slv_rsp_o` in t+1. RspCut=0 → same cycle.
- cnt_full is registered, with no same-cycle bypass. A response arriving while full frees issue in the next cycle.
- No combinational path from `mst_rsp_i.q_ready` to `slv_rsp_o.q_ready`.

## Test plan
- **Streaming reads:**
  - Stimulus: 16 back-to-back reads, addresses 0x0..0x3C; downstream `q_ready`=1; fixed 1-cycle response; RspCut=1.
  - Required response: 16 `mst` requests in consecutive cycles starting at t+1; responses reach the SSR at t+3..t+18 in order; `outstanding_o` ≤ 2; `idle_o`=1 afterwards.
- **Downstream stall:**
  - Stimulus: hold `mst q_ready`=0 for 5 cycles while the SSR streams.
  - Required response: A and B fill; `slv q_ready`=0 for the stall plus 1 cycle; after release, addresses appear in original order with no gap or duplicate.
- **Outstanding limit:**
  - Stimulus: MaxOutstanding=4; interconnect accepts but withholds responses.
  - Required response: exactly 4 issued, `mst q_valid`=0 while `outstanding_o`=4; one `p_valid` → the next request issues one cycle later.
- **Write/read mix:**
  - Stimulus: 3 writes (strb=0xFF, data 0xA5..) then 2 reads.
  - Required response: 5 `p_valid`s forwarded; `outstanding_o` returns to 0; payload fields bit-exact.
- **Simultaneous events and RspCut=0:**
  - Stimulus: issue and response in the same cycle.
  - Required response: count unchanged; with RspCut=0, `slv p_valid` coincides with `mst p_valid`.
- **Reset mid-operation:**
  - Stimulus: assert `rst_i` with A and B full and count=3.
  - Required response: `mst q_valid`=0, `slv q_ready`=1 and `idle_o`=1 without waiting for a clock edge; late responses ignored, no assertion fired.

Source files
------------

// File: rtl/snitch_ssr_tcdm_cut.sv
// Registered cut between an SSR TCDM master port and the cluster interconnect.
// A two-entry spill register breaks the q_ready path. An optional response
// register cuts the p-channel. An outstanding counter bounds in-flight
// requests and reports when the port is quiet enough to reconfigure the SSR.

package snitch_ssr_tcdm_cut_pkg;

  // Default TCDM request/response layout (32-bit address, 64-bit data)
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [0:0]  user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    tcdm_rsp_chan_t p;
    logic           p_valid;
    logic           q_ready;
  } tcdm_rsp_t;

endpackage

module snitch_ssr_tcdm_cut #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter type         tcdm_req_t     = snitch_ssr_tcdm_cut_pkg::tcdm_req_t,
  parameter type         tcdm_rsp_t     = snitch_ssr_tcdm_cut_pkg::tcdm_rsp_t,
  parameter bit          RspCut         = 1'b1,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  tcdm_req_t           slv_req_i,
  output tcdm_rsp_t           slv_rsp_o,
  output tcdm_req_t           mst_req_o,
  input  tcdm_rsp_t           mst_rsp_i,
  output logic                idle_o,
  output logic [CntWidth-1:0] outstanding_o
);

  // Spill register state: A is the output stage, B the skid entry.
  // The stored q_valid bit is ignored; the valid flags live separately.
  logic      a_valid_reg, a_valid_next;
  logic      b_valid_reg, b_valid_next;
  tcdm_req_t a_data_reg, a_data_next;
  tcdm_req_t b_data_reg, b_data_next;

  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic                cnt_full;
  logic                slv_hs;
  logic                issue;
  logic                rsp_evt;

  // Response-path results, produced by the RspCut generate branch
  tcdm_rsp_t rsp_payload;
  logic      rsp_p_valid;
  logic      rsp_pending;

  // cnt_full comes straight from the counter register: a response freeing a
  // slot only enables issue in the following cycle.
  assign cnt_full = (cnt_reg == CntWidth'(MaxOutstanding));
  assign slv_hs   = slv_req_i.q_valid & ~b_valid_reg;
  assign issue    = a_valid_reg & ~cnt_full & mst_rsp_i.q_ready;
  // A response with nothing outstanding is dropped (e.g. late after reset)
  assign rsp_evt  = mst_rsp_i.p_valid & (cnt_reg != '0);

  // Spill register next state: fill A when it is free, otherwise skid into B
  always_comb begin
    a_valid_next = a_valid_reg;
    b_valid_next = b_valid_reg;
    a_data_next  = a_data_reg;
    b_data_next  = b_data_reg;
    if (!a_valid_reg || issue) begin
      if (b_valid_reg) begin
        // B is older than anything the slave can offer (q_ready is low)
        a_valid_next = 1'b1;
        a_data_next  = b_data_reg;
        b_valid_next = 1'b0;
      end else begin
        a_valid_next = slv_hs;
        if (slv_hs) a_data_next = slv_req_i;
      end
    end else if (slv_hs) begin
      b_valid_next = 1'b1;
      b_data_next  = slv_req_i;
    end
  end

  // Spill register valid flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
    end else begin
      a_valid_reg <= a_valid_next;
      b_valid_reg <= b_valid_next;
    end
  end

  // Spill register payloads, deliberately without reset
  always_ff @(posedge clk_i) begin
    a_data_reg <= a_data_next;
    b_data_reg <= b_data_next;
  end

  // Outstanding counter next state; simultaneous issue and response cancel
  always_comb begin
    cnt_next = cnt_reg;
    if (issue && !rsp_evt) begin
      cnt_next = cnt_reg + CntWidth'(1);
    end else if (!issue && rsp_evt) begin
      cnt_next = cnt_reg - CntWidth'(1);
    end
  end

  // Outstanding counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  if (RspCut) begin : g_rsp_cut
    logic      rsp_valid_reg;
    tcdm_rsp_t rsp_data_reg;

    // Response valid is registered every cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rsp_valid_reg <= 1'b0;
      end else begin
        rsp_valid_reg <= rsp_evt;
      end
    end

    // Response data only loads on a valid response
    always_ff @(posedge clk_i) begin
      if (rsp_evt) rsp_data_reg <= mst_rsp_i;
    end

    assign rsp_payload = rsp_data_reg;
    assign rsp_p_valid = rsp_valid_reg;
    assign rsp_pending = rsp_valid_reg;
  end else begin : g_rsp_pass
    assign rsp_payload = mst_rsp_i;
    assign rsp_p_valid = rsp_evt;
    assign rsp_pending = 1'b0;
  end

  // Downstream request: A payload, valid gated by the in-flight limit
  always_comb begin
    mst_req_o         = a_data_reg;
    mst_req_o.q_valid = a_valid_reg & ~cnt_full;
  end

  // Upstream response: q_ready depends on register state only
  always_comb begin
    slv_rsp_o         = rsp_payload;
    slv_rsp_o.p_valid = rsp_p_valid;
    slv_rsp_o.q_ready = ~b_valid_reg;
  end

  assign idle_o        = ~a_valid_reg & ~b_valid_reg & (cnt_reg == '0) & ~rsp_pending;
  assign outstanding_o = cnt_reg;

`ifndef SYNTHESIS
  // Short window after reset in which stray responses are tolerated
  logic [2:0] quiet_reg;

  // Count down the post-reset tolerance window
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quiet_reg <= 3'd4;
    end else if (quiet_reg != 3'd0) begin
      quiet_reg <= quiet_reg - 3'd1;
    end
  end

  a_params : assert property (@(posedge clk_i)
    (AddrWidth > 0) && (DataWidth > 0) && (MaxOutstanding >= 1) && (MaxOutstanding <= 255));

  a_rsp_without_req : assert property (@(posedge clk_i) disable iff (rst_i)
    !(mst_rsp_i.p_valid && (cnt_reg == '0) && (quiet_reg == 3'd0)))
    else $error("response received with no outstanding request");
`endif

endmodule

// File: tb/tb_snitch_ssr_tcdm_cut.sv
// Directed testbench for snitch_ssr_tcdm_cut: one registered-response
// instance with MaxOutstanding=4 and one pass-through instance.
module tb_snitch_ssr_tcdm_cut;
  import snitch_ssr_tcdm_cut_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tcdm_req_t s_req, m_req, s_req0, m_req0;
  tcdm_rsp_t s_rsp, m_rsp, s_rsp0, m_rsp0;
  logic       idle, idle0;
  logic [2:0] outst;
  logic [3:0] outst0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snitch_ssr_tcdm_cut #(
    .AddrWidth(32), .DataWidth(64), .tcdm_req_t(tcdm_req_t), .tcdm_rsp_t(tcdm_rsp_t),
    .RspCut(1'b1), .MaxOutstanding(4)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(s_req), .slv_rsp_o(s_rsp),
    .mst_req_o(m_req), .mst_rsp_i(m_rsp), .idle_o(idle), .outstanding_o(outst)
  );

  snitch_ssr_tcdm_cut #(
    .AddrWidth(32), .DataWidth(64), .tcdm_req_t(tcdm_req_t), .tcdm_rsp_t(tcdm_rsp_t),
    .RspCut(1'b0), .MaxOutstanding(8)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .slv_req_i(s_req0), .slv_rsp_o(s_rsp0),
    .mst_req_o(m_req0), .mst_rsp_i(m_rsp0), .idle_o(idle0), .outstanding_o(outst0)
  );

  function automatic logic [63:0] rsp_of(input logic [31:0] a);
    return {32'hD00D_0000, a};
  endfunction

  function automatic tcdm_req_chan_t make_q(input int k);
    tcdm_req_chan_t q;
    q.addr  = 32'h300 + 32'(4 * k);
    q.write = (k < 3);
    q.amo   = 4'h0;
    q.data  = (k < 3) ? (64'hA5A5_A5A5_A5A5_A5A5 + 64'(k)) : 64'h0;
    q.strb  = (k < 3) ? 8'hFF : 8'h00;
    q.user  = 1'(k & 1);
    return q;
  endfunction

  task automatic test_reset();
    s_req = '0; m_rsp = '0; s_req0 = '0; m_rsp0 = '0;
    rst = 1'b1;
    #12;
    n_checks++; if (m_req.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mq_valid got %b expected 0", m_req.q_valid); end
    n_checks++; if (s_rsp.q_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sq_ready got %b expected 1", s_rsp.q_ready); end
    n_checks++; if (s_rsp.p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sp_valid got %b expected 0", s_rsp.p_valid); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b expected 1", idle); end
    n_checks++; if (outst !== 3'd0) begin n_fail++; $display("FAIL reset_outst got %0d expected 0", outst); end
    n_checks++; if (idle0 !== 1'b1) begin n_fail++; $display("FAIL reset_idle0 got %b expected 1", idle0); end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic pend = 1'b0;
    logic [63:0] pend_data = '0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      s_req = '0; s_req.q_valid = (c < 16); s_req.q.addr = 32'(4 * c);
      m_rsp = '0; m_rsp.q_ready = 1'b1; m_rsp.p_valid = pend; m_rsp.p.data = pend_data;
      #1;
      if (c < 16) begin
        n_checks++; if (s_rsp.q_ready !== 1'b1) begin n_fail++; $display("FAIL stream_sq_ready c=%0d got %b expected 1", c, s_rsp.q_ready); end
      end
      n_checks++; if (m_req.q_valid !== (c >= 1 && c <= 16)) begin n_fail++; $display("FAIL stream_mq_valid c=%0d got %b expected %b", c, m_req.q_valid, (c >= 1 && c <= 16)); end
      if (c >= 1 && c <= 16) begin
        n_checks++; if (m_req.q.addr !== 32'(4 * (c - 1))) begin n_fail++; $display("FAIL stream_addr c=%0d got %h expected %h", c, m_req.q.addr, 32'(4 * (c - 1))); end
      end
      n_checks++; if (s_rsp.p_valid !== (c >= 3 && c <= 18)) begin n_fail++; $display("FAIL stream_sp_valid c=%0d got %b expected %b", c, s_rsp.p_valid, (c >= 3 && c <= 18)); end
      if (c >= 3 && c <= 18) begin
        n_checks++; if (s_rsp.p.data !== rsp_of(32'(4 * (c - 3)))) begin n_fail++; $display("FAIL stream_rdata c=%0d got %h expected %h", c, s_rsp.p.data, rsp_of(32'(4 * (c - 3)))); end
      end
      n_checks++; if ((outst <= 3'd2) !== 1'b1) begin n_fail++; $display("FAIL stream_outst c=%0d got %0d expected <=2", c, outst); end
      pend = m_req.q_valid & m_rsp.q_ready;
      pend_data = rsp_of(m_req.q.addr);
    end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL stream_idle got %b expected 1", idle); end
    n_checks++; if (outst !== 3'd0) begin n_fail++; $display("FAIL stream_outst_end got %0d expected 0", outst); end
    $display("test_stream done");
  endtask

  task automatic test_stall();
    logic pend = 1'b0;
    logic [63:0] pend_data = '0;
    int idx = 0, niss = 0, nrsp = 0, exp_c;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      s_req = '0; s_req.q_valid = (idx < 10); s_req.q.addr = 32'h100 + 32'(4 * idx);
      m_rsp = '0; m_rsp.q_ready = !(c >= 2 && c <= 6); m_rsp.p_valid = pend; m_rsp.p.data = pend_data;
      #1;
      n_checks++; if (s_rsp.q_ready !== !(c >= 3 && c <= 7)) begin n_fail++; $display("FAIL stall_sq_ready c=%0d got %b expected %b", c, s_rsp.q_ready, !(c >= 3 && c <= 7)); end
      if (c >= 2 && c <= 6) begin
        n_checks++; if (m_req.q_valid !== 1'b1 || m_req.q.addr !== 32'h104) begin n_fail++; $display("FAIL stall_hold c=%0d got v=%b a=%h expected v=1 a=104", c, m_req.q_valid, m_req.q.addr); end
      end
      if (m_req.q_valid && m_rsp.q_ready) begin
        exp_c = (niss == 0) ? 1 : niss + 6;
        n_checks++; if (m_req.q.addr !== 32'h100 + 32'(4 * niss)) begin n_fail++; $display("FAIL stall_order c=%0d got %h expected %h", c, m_req.q.addr, 32'h100 + 32'(4 * niss)); end
        n_checks++; if (c !== exp_c) begin n_fail++; $display("FAIL stall_issue_cycle req=%0d got %0d expected %0d", niss, c, exp_c); end
        niss++;
      end
      if (s_rsp.p_valid) begin
        n_checks++; if (s_rsp.p.data !== rsp_of(32'h100 + 32'(4 * nrsp))) begin n_fail++; $display("FAIL stall_rdata got %h expected %h", s_rsp.p.data, rsp_of(32'h100 + 32'(4 * nrsp))); end
        nrsp++;
      end
      if (s_req.q_valid && s_rsp.q_ready) idx++;
      pend = m_req.q_valid & m_rsp.q_ready;
      pend_data = rsp_of(m_req.q.addr);
    end
    n_checks++; if (niss !== 10) begin n_fail++; $display("FAIL stall_issued got %0d expected 10", niss); end
    n_checks++; if (nrsp !== 10) begin n_fail++; $display("FAIL stall_responses got %0d expected 10", nrsp); end
    $display("test_stall done");
  endtask

  task automatic test_outstanding();
    int idx = 0, niss = 0;
    bit done = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      s_req = '0; s_req.q_valid = (idx < 6); s_req.q.addr = 32'h200 + 32'(4 * idx);
      m_rsp = '0; m_rsp.q_ready = 1'b1; m_rsp.p_valid = (c == 8); m_rsp.p.data = rsp_of(32'h200);
      #1;
      if (c >= 5 && c <= 8) begin
        n_checks++; if (m_req.q_valid !== 1'b0 || outst !== 3'd4) begin n_fail++; $display("FAIL limit_full c=%0d got v=%b n=%0d expected v=0 n=4", c, m_req.q_valid, outst); end
      end
      if (c == 6) begin
        n_checks++; if (s_rsp.q_ready !== 1'b0) begin n_fail++; $display("FAIL limit_sq_ready got %b expected 0", s_rsp.q_ready); end
      end
      if (c == 9) begin
        n_checks++; if (m_req.q_valid !== 1'b1 || m_req.q.addr !== 32'h210 || outst !== 3'd3) begin n_fail++; $display("FAIL limit_release got v=%b a=%h n=%0d expected v=1 a=210 n=3", m_req.q_valid, m_req.q.addr, outst); end
      end
      if (c == 10) begin
        n_checks++; if (m_req.q_valid !== 1'b0 || outst !== 3'd4) begin n_fail++; $display("FAIL limit_refull got v=%b n=%0d expected v=0 n=4", m_req.q_valid, outst); end
      end
      n_checks++; if (s_rsp.p_valid !== (c == 9)) begin n_fail++; $display("FAIL limit_sp_valid c=%0d got %b expected %b", c, s_rsp.p_valid, (c == 9)); end
      if (c <= 8 && m_req.q_valid && m_rsp.q_ready) niss++;
      if (s_req.q_valid && s_rsp.q_ready) idx++;
    end
    n_checks++; if (niss !== 4) begin n_fail++; $display("FAIL limit_issued got %0d expected 4", niss); end
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      s_req = '0;
      m_rsp = '0; m_rsp.q_ready = 1'b1; m_rsp.p_valid = (outst != 3'd0); m_rsp.p.data = 64'h0;
      #1;
      if (idle === 1'b1) done = 1;
    end
    n_checks++; if (idle !== 1'b1 || outst !== 3'd0) begin n_fail++; $display("FAIL limit_drain got idle=%b n=%0d expected idle=1 n=0", idle, outst); end
    $display("test_outstanding done");
  endtask

  task automatic test_write_mix();
    logic pend = 1'b0;
    logic [63:0] pend_data = '0;
    int idx = 0, niss = 0, nrsp = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      s_req = '0; s_req.q_valid = (idx < 5); s_req.q = make_q(idx);
      m_rsp = '0; m_rsp.q_ready = 1'b1; m_rsp.p_valid = pend; m_rsp.p.data = pend_data;
      #1;
      if (m_req.q_valid && m_rsp.q_ready) begin
        n_checks++; if (m_req.q !== make_q(niss)) begin n_fail++; $display("FAIL mix_payload req=%0d got %h expected %h", niss, m_req.q, make_q(niss)); end
        niss++;
      end
      if (s_rsp.p_valid) nrsp++;
      if (s_req.q_valid && s_rsp.q_ready) idx++;
      pend = m_req.q_valid & m_rsp.q_ready;
      pend_data = rsp_of(m_req.q.addr);
    end
    n_checks++; if (niss !== 5) begin n_fail++; $display("FAIL mix_issued got %0d expected 5", niss); end
    n_checks++; if (nrsp !== 5) begin n_fail++; $display("FAIL mix_responses got %0d expected 5", nrsp); end
    n_checks++; if (outst !== 3'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL mix_idle got n=%0d idle=%b expected n=0 idle=1", outst, idle); end
    $display("test_write_mix done");
  endtask

  task automatic test_simultaneous();
    logic pend = 1'b0;
    logic [63:0] pend_data = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      s_req0 = '0; s_req0.q_valid = (c < 2); s_req0.q.addr = 32'h400 + 32'(4 * c);
      m_rsp0 = '0; m_rsp0.q_ready = 1'b1; m_rsp0.p_valid = pend; m_rsp0.p.data = pend_data;
      #1;
      n_checks++; if (m_req0.q_valid !== (c == 1 || c == 2)) begin n_fail++; $display("FAIL sim_mq_valid c=%0d got %b expected %b", c, m_req0.q_valid, (c == 1 || c == 2)); end
      n_checks++; if (s_rsp0.p_valid !== (c == 2 || c == 3)) begin n_fail++; $display("FAIL sim_sp_valid c=%0d got %b expected %b", c, s_rsp0.p_valid, (c == 2 || c == 3)); end
      if (c == 2 || c == 3) begin
        n_checks++; if (s_rsp0.p.data !== rsp_of(32'h400 + 32'(4 * (c - 2)))) begin n_fail++; $display("FAIL sim_rdata c=%0d got %h expected %h", c, s_rsp0.p.data, rsp_of(32'h400 + 32'(4 * (c - 2)))); end
      end
      if (c == 2 || c == 3) begin
        n_checks++; if (outst0 !== 4'd1) begin n_fail++; $display("FAIL sim_count c=%0d got %0d expected 1", c, outst0); end
      end
      if (c == 4) begin
        n_checks++; if (outst0 !== 4'd0) begin n_fail++; $display("FAIL sim_count_end got %0d expected 0", outst0); end
      end
      pend = m_req0.q_valid & m_rsp0.q_ready;
      pend_data = rsp_of(m_req0.q.addr);
    end
    n_checks++; if (idle0 !== 1'b1) begin n_fail++; $display("FAIL sim_idle got %b expected 1", idle0); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_req = '0; s_req.q_valid = 1'b1; s_req.q.addr = 32'h500 + 32'(4 * idx);
      m_rsp = '0; m_rsp.q_ready = (c <= 3);
      #1;
      if (c == 5) begin
        n_checks++; if (m_req.q_valid !== 1'b1 || s_rsp.q_ready !== 1'b0 || outst !== 3'd3 || idle !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre got v=%b r=%b n=%0d idle=%b expected v=1 r=0 n=3 idle=0", m_req.q_valid, s_rsp.q_ready, outst, idle); end
      end
      if (s_req.q_valid && s_rsp.q_ready) idx++;
    end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (m_req.q_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mq_valid got %b expected 0", m_req.q_valid); end
    n_checks++; if (s_rsp.q_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_sq_ready got %b expected 1", s_rsp.q_ready); end
    n_checks++; if (idle !== 1'b1 || outst !== 3'd0) begin n_fail++; $display("FAIL rstmid_idle got idle=%b n=%0d expected idle=1 n=0", idle, outst); end
    @(negedge clk);
    s_req = '0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_rsp = '0; m_rsp.q_ready = 1'b1; m_rsp.p_valid = (c < 3); m_rsp.p.data = 64'hDEAD;
      #1;
      n_checks++; if (s_rsp.p_valid !== 1'b0 || outst !== 3'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_late c=%0d got pv=%b n=%0d idle=%b expected pv=0 n=0 idle=1", c, s_rsp.p_valid, outst, idle); end
    end
    m_rsp = '0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_outstanding();
    test_write_mix();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
